data_ram_resp: RTL and testbench
================================

Name: data_ram_resp

Overview:
- Responder end of the CPU data-memory port: accepts the MEM stage's ce/we/addr/sel/data request and serves it from an internal word-organised RAM.
- Access latency is configurable (wait states). The block raises stall_req_o toward the pipeline controller while a request is in flight, then pulses ready_o with read data.
- Sits beside the CPU top, on the ram_* side opposite the MEM stage.

Parameters:
- ADDR_W, 10, word-address bits; RAM depth = 2**ADDR_W words (default 4 KiB).
- WAIT_CYCLES, 1, extra cycles between acceptance and response (0..15).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce_i  in  1  request valid (chip enable from MEM stage).
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address; bits [1:0] ignored.
- sel_i  in  4  byte lanes; sel_i[3] = data[31:24] (big-endian lane order), sel_i[0] = data[7:0].
- data_i  in  32  write data.
- data_o  out  32  read data, valid while ready_o = 1.
- ready_o  out  1  one-cycle response pulse.
- stall_req_o  out  1  pipeline stall request while busy.
- err_o  out  1  out-of-range flag, valid with ready_o.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE, counter 0, data_o = 0, ready_o = 0, stall_req_o = 0, err_o = 0, latched request cleared. RAM contents are not reset and are retained across reset.
- States: IDLE, WAIT, RESP.
- Acceptance: a request is accepted only in IDLE or RESP when ce_i = 1. On acceptance, addr/we/sel/data are latched, and ce_i is not sampled again until the next IDLE/RESP.
  - WAIT_CYCLES > 0: next state WAIT, counter loaded with WAIT_CYCLES-1.
  - WAIT_CYCLES = 0: next state RESP.
- WAIT: the counter decrements each cycle. At counter = 0 the access is performed and the next state is RESP.
- Access, for an in-range address:
  - Write: updates only the bytes whose sel bit is 1. sel = 0000 is a legal no-op write.
  - Read: returns the full word; sel is ignored and the MEM stage performs lane extraction.
  - The RAM is written exactly once per write request.
- RESP: ready_o = 1 for exactly one cycle. data_o holds the read word on a read and 0 on a write. err_o is valid in this cycle.
  - RESP with ce_i = 1: new request accepted back-to-back (next state WAIT or RESP).
  - RESP with ce_i = 0: next state IDLE.
- stall_req_o:
  - Combinationally 1 in IDLE when ce_i = 1.
  - 1 throughout WAIT.
  - 0 in RESP.
  - Net effect: the requester is held for exactly 1 + WAIT_CYCLES cycles and released on the ready_o cycle.
- Out of range: when addr[31:ADDR_W+2] != 0, no RAM write occurs, data_o = 0, and err_o = 1 with ready_o. Timing is identical to an in-range access.
- Read-after-write on the same word in consecutive requests returns the new data (the write commits before the next access).
- Reset mid-operation aborts the request. A write still in WAIT is not committed. No ready_o pulse follows reset.

Optional Feature:
- Macro DATA_RAM_PARITY_EN.
- Defined:
  - Each byte stores an even-parity bit, written with the data under the sel lanes.
  - On a read, any lane parity mismatch sets err_o = 1 with ready_o (data_o is still returned).
  - An extra input par_inj_i (1 bit) inverts the stored parity bit of lane 0 on writes, for test.
- Undefined: no parity storage, no par_inj_i port, and err_o reflects out-of-range only.

Decomposition:
- Shared package data_ram_pkg:
  - state enum {IDLE, WAIT, RESP};
  - SEL_W = 4;
  - lane index constants (LANE_B3..LANE_B0);
  - helper function for word-index extraction from a byte address.
- Sub-module data_ram_array: single-port, byte-lane-enabled RAM of 2**ADDR_W x 32 bits (x 36 when parity is enabled), with a synchronous write and a read port. The FSM, counter and handshake stay in data_ram_resp.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF to 0x40 with sel=1111 -> stall_req_o high for 2 cycles, ready_o on cycle 2. Read 0x40 -> data_o=0xDEADBEEF, err_o=0.
- Byte write 0x000000AA to 0x40 with sel=0001, then read 0x40 -> 0xDEADBEAA. A write with sel=1000 and data 0x11000000 -> 0x11ADBEAA... the read after it returns 0x11ADBEAA.
- WAIT_CYCLES=0 with back-to-back ce_i held: write 0x12345678 @0x80, then read @0x80 -> ready_o on consecutive cycles, read returns 0x12345678, stall_req_o never high in RESP.
- Out of range, ADDR_W=10: read 0x00001000 -> ready_o=1, err_o=1, data_o=0. A write to 0x1000 does not alias: a subsequent read @0x0 is unchanged.
- Reset mid-operation: write 0xCAFEF00D to 0x10 with WAIT_CYCLES=3, assert rst low in the 2nd WAIT cycle -> all outputs 0 immediately, no ready_o, and a later read @0x10 returns the old value.
- DATA_RAM_PARITY_EN: write 0xFFFFFFFF to 0x20 with par_inj_i=1, then read 0x20 -> err_o=1, data_o=0xFFFFFFFF. Rewrite with par_inj_i=0 -> err_o=0.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data-memory responder.
// DATA_RAM_PARITY_EN widens each byte lane with an even-parity bit.
package data_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned LANE_B3 = 3;
    localparam int unsigned LANE_B2 = 2;
    localparam int unsigned LANE_B1 = 1;
    localparam int unsigned LANE_B0 = 0;

`ifdef DATA_RAM_PARITY_EN
    localparam int unsigned LANE_W = 9;
`else
    localparam int unsigned LANE_W = 8;
`endif

    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port, byte-lane-enabled word RAM: synchronous write, asynchronous read.
// Lane width comes from the instantiator (8, or 9 with DATA_RAM_PARITY_EN).
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned LANE_BITS = 8
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [SEL_W-1:0]             be_i,
    input  logic [SEL_W*LANE_BITS-1:0]   wdata_i,
    output logic [SEL_W*LANE_BITS-1:0]   rdata_o
);

    logic [SEL_W*LANE_BITS-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned k = 0; k < SEL_W; k++) begin
                if (be_i[k]) begin
                    mem_q[addr_i][k*LANE_BITS +: LANE_BITS] <= wdata_i[k*LANE_BITS +: LANE_BITS];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: IDLE/WAIT/RESP handshake with configurable wait states.
// DATA_RAM_PARITY_EN adds per-byte parity storage, parity error reporting and par_inj_i.
module data_ram_resp
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
`ifdef DATA_RAM_PARITY_EN
    input  logic        par_inj_i,
`endif
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        stall_req_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] req_data_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        do_access;

    logic        direct;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [3:0]  acc_sel;
    logic [31:0] acc_data;
    logic        in_range;
    logic        mem_we;
    logic [ADDR_W-1:0]         acc_idx;
    logic [SEL_W*LANE_W-1:0]   wdata;
    logic [SEL_W*LANE_W-1:0]   rdata;
    logic [31:0] rword;
    logic        par_err;

`ifdef DATA_RAM_PARITY_EN
    logic        inj_q;
    logic        acc_inj;
`endif

    assign accept = ce_i && (state_q == IDLE || state_q == RESP);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (ce_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-wait accesses happen in the acceptance cycle, so they use the live request.
    assign direct   = (state_q != WAIT);
    assign acc_we   = direct ? we_i   : we_q;
    assign acc_addr = direct ? addr_i : addr_q;
    assign acc_sel  = direct ? sel_i  : sel_q;
    assign acc_data = direct ? data_i : req_data_q;
`ifdef DATA_RAM_PARITY_EN
    assign acc_inj  = direct ? par_inj_i : inj_q;
`endif

    assign in_range = ((acc_addr >> (ADDR_W + 2)) == '0);
    assign acc_idx  = ADDR_W'(word_index(acc_addr));
    assign mem_we   = do_access && acc_we && in_range && rst;

    always_comb begin
        wdata   = '0;
        rword   = '0;
        par_err = 1'b0;
        for (int unsigned k = 0; k <= LANE_B3; k++) begin
            wdata[k*LANE_W +: 8] = acc_data[k*8 +: 8];
            rword[k*8 +: 8]      = rdata[k*LANE_W +: 8];
`ifdef DATA_RAM_PARITY_EN
            wdata[k*LANE_W + 8] = (^acc_data[k*8 +: 8]) ^ ((k == LANE_B0) && acc_inj);
            par_err = par_err | (rdata[k*LANE_W + 8] != (^rdata[k*LANE_W +: 8]));
`endif
        end
    end

    data_ram_array #(
        .ADDR_W   (ADDR_W),
        .LANE_BITS(LANE_W)
    ) u_array (
        .clk    (clk),
        .we_i   (mem_we),
        .addr_i (acc_idx),
        .be_i   (acc_sel),
        .wdata_i(wdata),
        .rdata_o(rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            req_data_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef DATA_RAM_PARITY_EN
            inj_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q       <= we_i;
                addr_q     <= addr_i;
                sel_q      <= sel_i;
                req_data_q <= data_i;
`ifdef DATA_RAM_PARITY_EN
                inj_q      <= par_inj_i;
`endif
            end
            if (do_access) begin
                rdata_q <= (!acc_we && in_range) ? rword : '0;
                err_q   <= !in_range || (!acc_we && par_err);
            end
        end
    end

    assign ready_o     = (state_q == RESP);
    assign data_o      = ready_o ? rdata_q : '0;
    assign err_o       = ready_o && err_q;
    assign stall_req_o = (state_q == WAIT) || (state_q == IDLE && ce_i);

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: three instances (WAIT_CYCLES 1, 0, 3), directed vectors.
// Parity vectors are included when DATA_RAM_PARITY_EN is defined.
module tb_data_ram_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ce    [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [3:0]  sel   [3];
    logic [31:0] din   [3];
    logic [31:0] dout  [3];
    logic        rdy   [3];
    logic        stall [3];
    logic        err   [3];
`ifdef DATA_RAM_PARITY_EN
    logic        inj   [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_ram_resp #(
            .ADDR_W     (10),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .ce_i       (ce[g]),
            .we_i       (we[g]),
            .addr_i     (addr[g]),
            .sel_i      (sel[g]),
            .data_i     (din[g]),
`ifdef DATA_RAM_PARITY_EN
            .par_inj_i  (inj[g]),
`endif
            .data_o     (dout[g]),
            .ready_o    (rdy[g]),
            .stall_req_o(stall[g]),
            .err_o      (err[g])
        );
    end

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic int wc_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every ready pulse consumes the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rdy[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_dut", 32'(d), 32'(e.dut));
                    check("resp_data", dout[d], e.data);
                    check("resp_err", {31'b0, err[d]}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        int  stalls;
        int  n;
        bit  got;
        exp_t e;
        e.dut = d; e.data = exp_d; e.err = exp_e;
        sb.push_back(e);
        @(posedge clk); #1;
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = wd;
        @(negedge clk);
        stalls = (stall[d] === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        ce[d] = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (rdy[d] === 1'b1) got = 1'b1;
            else if (stall[d] === 1'b1) stalls++;
        end
        if (!got) begin
            check("resp_timeout", 32'(n), 32'(0));
        end else begin
            check("stall_cycles", 32'(stalls), 32'(1 + wc_of(d)));
            check("stall_in_resp", {31'b0, stall[d]}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            ce[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; sel[d] = '0; din[d] = '0;
`ifdef DATA_RAM_PARITY_EN
            inj[d] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", {31'b0, rdy[d]}, 32'd0);
            check("rst_stall", {31'b0, stall[d]}, 32'd0);
            check("rst_data", dout[d], 32'd0);
            check("rst_err", {31'b0, err[d]}, 32'd0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // WAIT_CYCLES=1: full word, byte lanes, sel=0000 no-op, ignored low address bits
        txn(0, 1'b1, 32'h40, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h40, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b1, 32'h40, 4'b0001, 32'h0000_00AA, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h40, 4'b1111, 32'h0, 32'hDEAD_BEAA, 1'b0);
        txn(0, 1'b1, 32'h40, 4'b1000, 32'h1100_0000, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h40, 4'b1111, 32'h0, 32'h11AD_BEAA, 1'b0);
        txn(0, 1'b1, 32'h40, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h43, 4'b0001, 32'h0, 32'h11AD_BEAA, 1'b0);

        // Out of range: no aliasing onto word 0
        txn(0, 1'b1, 32'h0, 4'b1111, 32'h55AA_55AA, 32'h0, 1'b0);
        txn(0, 1'b1, 32'h1000, 4'b1111, 32'h9999_9999, 32'h0, 1'b1);
        txn(0, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h55AA_55AA, 1'b0);
        txn(0, 1'b0, 32'h1000, 4'b1111, 32'h0, 32'h0, 1'b1);
        txn(0, 1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h0, 32'h0, 1'b1);
        txn(0, 1'b0, 32'h0FFC, 4'b1111, 32'h0, 32'h0, 1'b0);

        // WAIT_CYCLES=0 back-to-back write then read with ce held
        begin
            exp_t e;
            @(posedge clk); #1;
            ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h80; sel[1] = 4'hF; din[1] = 32'h1234_5678;
            e.dut = 1; e.data = 32'h0; e.err = 1'b0; sb.push_back(e);
            @(negedge clk);
            check("b2b_stall_idle", {31'b0, stall[1]}, 32'd1);
            @(posedge clk); #1;
            we[1] = 1'b0; din[1] = 32'h0;
            e.dut = 1; e.data = 32'h1234_5678; e.err = 1'b0; sb.push_back(e);
            @(negedge clk);
            check("b2b_ready_wr", {31'b0, rdy[1]}, 32'd1);
            check("b2b_stall_resp_wr", {31'b0, stall[1]}, 32'd0);
            @(posedge clk); #1;
            ce[1] = 1'b0;
            @(negedge clk);
            check("b2b_ready_rd", {31'b0, rdy[1]}, 32'd1);
            check("b2b_stall_resp_rd", {31'b0, stall[1]}, 32'd0);
            @(negedge clk);
            check("b2b_idle_after", {31'b0, rdy[1]}, 32'd0);
        end

        // WAIT_CYCLES=3: reset in the 2nd WAIT cycle aborts the write
        txn(2, 1'b1, 32'h10, 4'b1111, 32'h1111_2222, 32'h0, 1'b0);
        txn(2, 1'b0, 32'h10, 4'b1111, 32'h0, 32'h1111_2222, 1'b0);
        @(posedge clk); #1;
        ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h10; sel[2] = 4'hF; din[2] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        ce[2] = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_stall", {31'b0, stall[2]}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'b0, rdy[2]}, 32'd0);
        check("midrst_stall", {31'b0, stall[2]}, 32'd0);
        check("midrst_data", dout[2], 32'd0);
        check("midrst_err", {31'b0, err[2]}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[2] === 1'b1) cnt++;
        end
        check("no_ready_after_rst", 32'(cnt), 32'd0);
        txn(2, 1'b0, 32'h10, 4'b1111, 32'h0, 32'h1111_2222, 1'b0);

`ifdef DATA_RAM_PARITY_EN
        inj[0] = 1'b1;
        txn(0, 1'b1, 32'h20, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b0);
        inj[0] = 1'b0;
        txn(0, 1'b0, 32'h20, 4'b1111, 32'h0, 32'hFFFF_FFFF, 1'b1);
        txn(0, 1'b1, 32'h20, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h20, 4'b1111, 32'h0, 32'hFFFF_FFFF, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
